mutation_mask_scheduler: RTL and testbench

- Shares one mutation-mask generator among REQ_COUNT mutation units.
- Arbitrates requests round-robin and drives the generator's per-requester mutate-count select.
- Presents the finished mask to the granted unit, then runs the maskUsed/maskReady release handshake that restarts the generator.
- Sits between the generator's maskUsed/maskReady/mutateCountSelect pins and the offspring mutation units.

---
 rtl/mutation_mask_scheduler.sv | 252 +++++++++++++++++++++++++
 tb/tb_mutation_mask_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mutation_mask_scheduler.sv
// mutation_mask_scheduler
// Shares one mutation-mask generator among REQ_COUNT mutation units.
// A round-robin arbiter picks the next owner, drives the generator's
// mutate-count select for that owner, presents the finished mask through a
// one-hot grant and then runs the maskUsed/maskReady release handshake that
// restarts the generator. A saturating watchdog bounds every wait on a
// maskReady edge and raises a sticky timeout_err when it expires.
//
// Build option: define MASK_SCHED_PRIORITY_EN to replace round-robin with
// fixed priority (lowest set request index wins; the last-owner pointer is
// then ignored by the arbiter).
module mutation_mask_scheduler #(
    parameter int REQ_COUNT      = 4,
    parameter int REQ_IDX_BIT    = 2,
    parameter int MUTATE_SEL_BIT = 4,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TIMEOUT_BIT    = 10
) (
    input  logic                                CLOCK_50,
    input  logic                                reset,
    input  logic [REQ_COUNT-1:0]                req,
    input  logic [REQ_COUNT*MUTATE_SEL_BIT-1:0] req_sel,
    input  logic [REQ_COUNT-1:0]                consumed,
    input  logic                                maskReady,
    output logic                                maskUsed,
    output logic [MUTATE_SEL_BIT-1:0]           mutateCountSelect,
    output logic [REQ_COUNT-1:0]                grant,
    output logic [REQ_IDX_BIT-1:0]              grant_idx,
    output logic                                busy,
    output logic                                timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARB        = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_SERVE      = 3'd3,
        ST_RELEASE    = 3'd4
    } state_t;

    localparam logic [TIMEOUT_BIT-1:0] WDOG_LIMIT = TIMEOUT_BIT'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_BIT-1:0] WDOG_LAST  = TIMEOUT_BIT'(TIMEOUT_CYCLES - 1);
    localparam logic [REQ_IDX_BIT-1:0] LAST_INIT  = REQ_IDX_BIT'(REQ_COUNT - 1);

    // Registered state and outputs
    state_t                    state_r;
    logic                      mask_used_r;
    logic [MUTATE_SEL_BIT-1:0] sel_r;
    logic [REQ_COUNT-1:0]      grant_r;
    logic [REQ_IDX_BIT-1:0]    grant_idx_r;
    logic                      busy_r;
    logic                      timeout_err_r;
    logic [REQ_IDX_BIT-1:0]    last_r;
    logic [TIMEOUT_BIT-1:0]    wdog_r;
    // Set after the first RELEASE cycle so maskUsed is held for at least two
    // cycles even if maskReady is already low when RELEASE is entered.
    logic                      rel_hold_r;

    // Next-state values
    state_t                    state_next_s;
    logic                      mask_used_next_s;
    logic [MUTATE_SEL_BIT-1:0] sel_next_s;
    logic [REQ_COUNT-1:0]      grant_next_s;
    logic [REQ_IDX_BIT-1:0]    grant_idx_next_s;
    logic                      busy_next_s;
    logic                      timeout_err_next_s;
    logic [REQ_IDX_BIT-1:0]    last_next_s;
    logic [TIMEOUT_BIT-1:0]    wdog_next_s;
    logic                      rel_hold_next_s;

    // Arbitration and helper terms
    logic [REQ_IDX_BIT-1:0]    winner_s;
    logic                      consume_s;
    logic                      wdog_hit_s;
    logic [TIMEOUT_BIT-1:0]    wdog_inc_s;

    // Round-robin pick: first set request scanning last+1, last+2, ... with wrap.
    function automatic logic [REQ_IDX_BIT-1:0] rr_pick(
        input logic [REQ_COUNT-1:0]   r,
        input logic [REQ_IDX_BIT-1:0] l
    );
        logic [REQ_IDX_BIT-1:0] pick;
        logic [REQ_IDX_BIT-1:0] jj;
        logic                   found;
        pick  = l;
        found = 1'b0;
        for (int k = 1; k <= REQ_COUNT; k++) begin
            jj = REQ_IDX_BIT'((int'(l) + k) % REQ_COUNT);
            if (!found && r[jj]) begin
                pick  = jj;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Fixed-priority pick: lowest set request index.
    function automatic logic [REQ_IDX_BIT-1:0] prio_pick(
        input logic [REQ_COUNT-1:0] r
    );
        logic [REQ_IDX_BIT-1:0] pick;
        pick = '0;
        for (int k = REQ_COUNT - 1; k >= 0; k--) begin
            if (r[k]) begin
                pick = REQ_IDX_BIT'(k);
            end
        end
        return pick;
    endfunction

    // Select the arbitration winner for the current request vector.
    always_comb begin
`ifdef MASK_SCHED_PRIORITY_EN
        winner_s = prio_pick(req);
`else
        winner_s = rr_pick(req, last_r);
`endif
    end

    // Consumption, watchdog expiry and saturating watchdog increment.
    always_comb begin
        consume_s  = consumed[grant_idx_r] | ~req[grant_idx_r];
        wdog_hit_s = (wdog_r >= WDOG_LAST);
        if (wdog_r == WDOG_LIMIT) begin
            wdog_inc_s = wdog_r;
        end else begin
            wdog_inc_s = wdog_r + {{(TIMEOUT_BIT-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and next-output logic of the scheduler FSM.
    always_comb begin
        state_next_s       = state_r;
        mask_used_next_s   = mask_used_r;
        sel_next_s         = sel_r;
        grant_next_s       = grant_r;
        grant_idx_next_s   = grant_idx_r;
        timeout_err_next_s = timeout_err_r;
        last_next_s        = last_r;
        wdog_next_s        = wdog_r;
        rel_hold_next_s    = rel_hold_r;

        case (state_r)
            ST_IDLE: begin
                if (req != '0) begin
                    state_next_s = ST_ARB;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_ARB: begin
                if (req != '0) begin
                    grant_idx_next_s = winner_s;
                    sel_next_s       = req_sel[winner_s * MUTATE_SEL_BIT +: MUTATE_SEL_BIT];
                    wdog_next_s      = '0;
                    state_next_s     = ST_WAIT_READY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_WAIT_READY: begin
                if (maskReady) begin
                    grant_next_s              = '0;
                    grant_next_s[grant_idx_r] = 1'b1;
                    state_next_s              = ST_SERVE;
                end else if (wdog_hit_s) begin
                    timeout_err_next_s = 1'b1;
                    mask_used_next_s   = 1'b0;
                    grant_next_s       = '0;
                    wdog_next_s        = WDOG_LIMIT;
                    state_next_s       = ST_IDLE;
                end else begin
                    wdog_next_s = wdog_inc_s;
                end
            end

            ST_SERVE: begin
                if (consume_s) begin
                    grant_next_s     = '0;
                    mask_used_next_s = 1'b1;
                    last_next_s      = grant_idx_r;
                    wdog_next_s      = '0;
                    rel_hold_next_s  = 1'b0;
                    state_next_s     = ST_RELEASE;
                end else begin
                    state_next_s = ST_SERVE;
                end
            end

            ST_RELEASE: begin
                if (rel_hold_r && !maskReady) begin
                    mask_used_next_s = 1'b0;
                    state_next_s     = ST_IDLE;
                end else if (wdog_hit_s) begin
                    timeout_err_next_s = 1'b1;
                    mask_used_next_s   = 1'b0;
                    grant_next_s       = '0;
                    wdog_next_s        = WDOG_LIMIT;
                    state_next_s       = ST_IDLE;
                end else begin
                    wdog_next_s     = wdog_inc_s;
                    rel_hold_next_s = 1'b1;
                end
            end

            default: begin
                mask_used_next_s = 1'b0;
                grant_next_s     = '0;
                state_next_s     = ST_IDLE;
            end
        endcase

        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            mask_used_r   <= 1'b0;
            sel_r         <= '0;
            grant_r       <= '0;
            grant_idx_r   <= '0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            last_r        <= LAST_INIT;
            wdog_r        <= '0;
            rel_hold_r    <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            mask_used_r   <= mask_used_next_s;
            sel_r         <= sel_next_s;
            grant_r       <= grant_next_s;
            grant_idx_r   <= grant_idx_next_s;
            busy_r        <= busy_next_s;
            timeout_err_r <= timeout_err_next_s;
            last_r        <= last_next_s;
            wdog_r        <= wdog_next_s;
            rel_hold_r    <= rel_hold_next_s;
        end
    end

    assign maskUsed          = mask_used_r;
    assign mutateCountSelect = sel_r;
    assign grant             = grant_r;
    assign grant_idx         = grant_idx_r;
    assign busy              = busy_r;
    assign timeout_err       = timeout_err_r;

endmodule

// File: tb/tb_mutation_mask_scheduler.sv
// Directed self-checking bench for mutation_mask_scheduler.
// Inputs are driven #1 after each rising edge and outputs are sampled there too.
module tb_mutation_mask_scheduler;

    logic        CLOCK_50;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_sel;
    logic [3:0]  consumed;
    logic        maskReady;
    logic        maskUsed;
    logic [3:0]  mutateCountSelect;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        busy;
    logic        timeout_err;

    int checks_s;
    int failures_s;

    logic [3:0] sel_tab_s [4];

    mutation_mask_scheduler dut (
        .CLOCK_50          (CLOCK_50),
        .reset             (reset),
        .req               (req),
        .req_sel           (req_sel),
        .consumed          (consumed),
        .maskReady         (maskReady),
        .maskUsed          (maskUsed),
        .mutateCountSelect (mutateCountSelect),
        .grant             (grant),
        .grant_idx         (grant_idx),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    // 50 MHz clock
    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_s++;
        if (got !== exp) begin
            failures_s++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req       = 4'b0000;
        consumed  = 4'b0000;
        maskReady = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // One full transaction from IDLE with the request vector rq held throughout.
    task automatic txn(input string tag, input int exp, input logic [3:0] rq);
        logic [3:0] onehot;
        onehot = 4'b0001 << exp;
        req = rq;
        tick();                         // IDLE -> ARB
        tick();                         // ARB -> WAIT_READY
        check_val({tag, "_idx"}, 32'(grant_idx), 32'(exp));
        check_val({tag, "_sel"}, 32'(mutateCountSelect), 32'(sel_tab_s[exp]));
        maskReady = 1'b1;
        tick();                         // -> SERVE
        check_val({tag, "_grant"}, 32'(grant), 32'(onehot));
        consumed = onehot;
        tick();                         // -> RELEASE
        consumed = 4'b0000;
        check_val({tag, "_used"}, 32'(maskUsed), 32'd1);
        tick();                         // minimum hold cycle
        maskReady = 1'b0;
        tick();                         // -> IDLE
        check_val({tag, "_release"}, 32'(maskUsed), 32'd0);
    endtask

    initial begin
        checks_s   = 0;
        failures_s = 0;
        sel_tab_s[0] = 4'h5;
        sel_tab_s[1] = 4'h7;
        sel_tab_s[2] = 4'hA;
        sel_tab_s[3] = 4'hC;
        req_sel = {4'hC, 4'hA, 4'h7, 4'h5};

        // Reset state
        do_reset();
        check_val("rst_used", 32'(maskUsed), 32'd0);
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_idx", 32'(grant_idx), 32'd0);
        check_val("rst_sel", 32'(mutateCountSelect), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_tmo", 32'(timeout_err), 32'd0);

        // Single requester, maskReady rises three cycles after ARB
        req = 4'b0001;
        tick();                         // ARB
        check_val("t1_busy_arb", 32'(busy), 32'd1);
        tick();                         // WAIT_READY
        check_val("t1_sel", 32'(mutateCountSelect), 32'h5);
        check_val("t1_idx", 32'(grant_idx), 32'd0);
        tick();
        tick();
        check_val("t1_wait_grant", 32'(grant), 32'd0);
        maskReady = 1'b1;
        tick();                         // SERVE
        check_val("t1_grant", 32'(grant), 32'b0001);
        check_val("t1_used_serve", 32'(maskUsed), 32'd0);
        consumed = 4'b0001;
        tick();                         // RELEASE
        consumed = 4'b0000;
        req      = 4'b0000;
        check_val("t1_used1", 32'(maskUsed), 32'd1);
        check_val("t1_grant_clr", 32'(grant), 32'd0);
        tick();
        check_val("t1_used2", 32'(maskUsed), 32'd1);
        tick();                         // maskReady still 1: hold
        check_val("t1_used3", 32'(maskUsed), 32'd1);
        check_val("t1_sel_hold", 32'(mutateCountSelect), 32'h5);
        maskReady = 1'b0;
        tick();                         // IDLE
        check_val("t1_used_off", 32'(maskUsed), 32'd0);
        check_val("t1_busy_off", 32'(busy), 32'd0);

        // All units requesting continuously
        do_reset();
`ifdef MASK_SCHED_PRIORITY_EN
        txn("t2a", 0, 4'b1111);
        txn("t2b", 0, 4'b1111);
        txn("t2c", 0, 4'b1111);
`else
        txn("t2a", 0, 4'b1111);
        txn("t2b", 1, 4'b1111);
        txn("t2c", 2, 4'b1111);
        txn("t2d", 3, 4'b1111);
        txn("t2e", 0, 4'b1111);
`endif
        req = 4'b0000;

        // Non-owner consumed ignored; dropping the owner's req counts as consumption
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        maskReady = 1'b1;
        tick();
        check_val("t3_grant", 32'(grant), 32'b0100);
        consumed = 4'b0010;
        tick();
        consumed = 4'b0000;
        check_val("t3_ignore_grant", 32'(grant), 32'b0100);
        check_val("t3_ignore_used", 32'(maskUsed), 32'd0);
        req = 4'b0000;
        tick();
        check_val("t3_drop_grant", 32'(grant), 32'd0);
        check_val("t3_drop_used", 32'(maskUsed), 32'd1);
        tick();
        maskReady = 1'b0;
        tick();
        check_val("t3_done", 32'(maskUsed), 32'd0);

        // Watchdog timeout while waiting for maskReady
        do_reset();
        req = 4'b0001;
        tick();                         // ARB
        tick();                         // WAIT_READY, watchdog 0
        for (int i = 0; i < 1022; i++) begin
            tick();
        end
        check_val("t4_pre_tmo", 32'(timeout_err), 32'd0);
        check_val("t4_pre_busy", 32'(busy), 32'd1);
        tick();
        req = 4'b0000;
        check_val("t4_tmo", 32'(timeout_err), 32'd1);
        check_val("t4_grant", 32'(grant), 32'd0);
        check_val("t4_used", 32'(maskUsed), 32'd0);
        check_val("t4_busy", 32'(busy), 32'd0);
        tick();
        tick();
        tick();
        check_val("t4_sticky", 32'(timeout_err), 32'd1);
        do_reset();
        check_val("t4_rst_clear", 32'(timeout_err), 32'd0);

        // Reset during RELEASE
        req = 4'b0010;
        tick();
        tick();
        check_val("t5_idx", 32'(grant_idx), 32'd1);
        maskReady = 1'b1;
        tick();
        consumed = 4'b0010;
        tick();
        consumed = 4'b0000;
        check_val("t5_used", 32'(maskUsed), 32'd1);
        reset = 1'b0;
        tick();
        check_val("t5_rst_used", 32'(maskUsed), 32'd0);
        check_val("t5_rst_grant", 32'(grant), 32'd0);
        check_val("t5_rst_busy", 32'(busy), 32'd0);
        check_val("t5_rst_idx", 32'(grant_idx), 32'd0);
        reset     = 1'b1;
        req       = 4'b0000;
        maskReady = 1'b0;
        tick();

        // req[3] arriving during unit 0's SERVE is served next
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        maskReady = 1'b1;
        tick();
        req = 4'b1001;
        tick();
        check_val("t6_grant0", 32'(grant), 32'b0001);
        consumed = 4'b0001;
        tick();
        consumed = 4'b0000;
        req      = 4'b1000;
        tick();
        maskReady = 1'b0;
        tick();
        check_val("t6_idle", 32'(busy), 32'd0);
        txn("t6", 3, 4'b1000);
        req = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

endmodule
